tick_counter_regs: RTL and testbench
====================================

// Module: tick_counter_regs
// PURPOSE
//  Sequencing primitive cluster: a free-running up-counter, a plain enabled register and a
//  mode-driven "tick" register (hold/set/inc/dec). Sits beside the instruction decoder.
//  The counter bits serve as phase strobes that drive register loads and tick-register modes.
//  All three state elements share one clock and one reset. Every output is registered.
// PARAMETERS
//  COUNT_WIDTH  6  width of free-running counter count_out
//  REG_SIZE     4  width of plain register reg_in/reg_out
//  TICK_WIDTH   8  width of tick register tick_in/tick_out
// PORTS
//  clk         in   1            system clock, all state updates on rising edge
//  rst         in   1            synchronous, active-high reset
//  count_out   out  COUNT_WIDTH  free-running counter value
//  reg_in      in   REG_SIZE     plain register data input
//  reg_enable  in   1            1 = load reg_in at next edge
//  reg_out     out  REG_SIZE     plain register contents
//  tick_in     in   TICK_WIDTH   tick register load value (SET mode)
//  tick_mode   in   2            operation select, see TICK_REGISTER_MODE_* constants
//  tick_out    out  TICK_WIDTH   tick register contents
// BEHAVIOUR
//  - One clock (clk); reset is synchronous and active-high (rst). Asserting rst has no
//    effect until the next rising clk edge.
//  - Reset value: count_out=0, reg_out=0, tick_out=0. Reset overrides every other input,
//    including reg_enable=1 and any tick_mode.
//  - Counter: count_out <= count_out+1 on each edge with rst=0; wraps 2^COUNT_WIDTH-1 -> 0
//    (63 -> 0 at default). No enable.
//  - Register: reg_enable=1 -> reg_out <= reg_in. reg_enable=0 -> hold. Latency 1 cycle.
//  - Tick register: tick_mode is decoded every edge:
//      2'b00 HOLD: tick_out unchanged
//      2'b01 SET : tick_out <= tick_in
//      2'b10 INC : tick_out <= tick_out+1, modulo 2^TICK_WIDTH
//      2'b11 DEC : tick_out <= tick_out-1, modulo 2^TICK_WIDTH
//    A mode masked by strobes (e.g. SET & {s1,s0}) may collapse to HOLD; HOLD is always legal.
//  - All arithmetic is unsigned at the declared width; carries are discarded.
//  - Reset mid-operation: state zeroes at the first edge with rst=1. Normal operation
//    resumes at the first edge with rst=0.
//  - Outputs are X-free after the first reset edge. No combinational input->output paths.
// CONFIGURATION
//  TICK_SATURATE_EN defined: INC at all-ones holds all-ones; DEC at 0 holds 0.
//  TICK_SATURATE_EN undefined (default): INC/DEC wrap modulo 2^TICK_WIDTH.
//  Counter and plain register are unaffected by the macro.
// STRUCTURE
//  - Shared include TickRegisterConstants.v holds TICK_REGISTER_MODE_HOLD/SET/INC/DEC
//    (2-bit) and the mode-width define. RTL and benches use these, never literals.
//  - Sub-module width_register (parameter SIZE; ports clk, rst, in, enable, out) implements
//    the plain register.
//  - Counter and tick-register next-state logic stay inline in this module.
// TESTING
//  1. rst=1 for 2 edges, then rst=0 -> count_out 0,1,2,... 63,0. Wrap seen at edge 64.
//  2. reg_in=count_out[3:0], reg_enable=1 -> reg_out equals count_out[3:0] of the prior
//     cycle. reg_enable=0 -> reg_out frozen.
//  3. tick_in=8'h05, mode=SET -> tick_out=8'h05 next edge. Mode alternating HOLD/SET keeps
//     tick_out at 8'h05.
//  4. From 8'h05: INC x3 -> 8'h08. From 8'h00: DEC -> 8'hFF (8'h00 with TICK_SATURATE_EN).
//     From 8'hFF: INC -> 8'h00 (8'hFF with TICK_SATURATE_EN).
//  5. rst=1 with reg_enable=1 and mode=SET -> all outputs 0 at that edge. No change before
//     the edge.
//  6. Reset pulse at count_out=37 -> count_out=0 next edge, then 1,2,... with rst=0.

Source files
------------

// File: rtl/tick_counter_regs_pkg.sv
// Shared constants for tick_counter_regs: default widths and the tick register mode encodings.
package tick_counter_regs_pkg;

  localparam int TICK_MODE_WIDTH = 2;

  typedef logic [TICK_MODE_WIDTH-1:0] tick_mode_t;

  localparam tick_mode_t TICK_REGISTER_MODE_HOLD = 2'b00;
  localparam tick_mode_t TICK_REGISTER_MODE_SET  = 2'b01;
  localparam tick_mode_t TICK_REGISTER_MODE_INC  = 2'b10;
  localparam tick_mode_t TICK_REGISTER_MODE_DEC  = 2'b11;

  localparam int DEFAULT_COUNT_WIDTH = 6;
  localparam int DEFAULT_REG_SIZE    = 4;
  localparam int DEFAULT_TICK_WIDTH  = 8;

endpackage

// File: rtl/tick_counter_regs_width_register.sv
// width_register: plain enabled register, loads in on enable, otherwise holds.
module width_register
  import tick_counter_regs_pkg::*;
#(
  parameter int SIZE = DEFAULT_REG_SIZE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] in,
  input  logic            enable,
  output logic [SIZE-1:0] out
);

  always_ff @(posedge clk) begin
    if (rst) begin
      out <= '0;
    end else if (enable) begin
      out <= in;
    end
  end

endmodule

// File: rtl/tick_counter_regs.sv
// tick_counter_regs: free-running counter, plain register and hold/set/inc/dec tick register.
// Optional macro TICK_SATURATE_EN: tick INC/DEC clamp at all-ones/zero instead of wrapping.
module tick_counter_regs
  import tick_counter_regs_pkg::*;
#(
  parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH,
  parameter int REG_SIZE    = DEFAULT_REG_SIZE,
  parameter int TICK_WIDTH  = DEFAULT_TICK_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [COUNT_WIDTH-1:0]     count_out,
  input  logic [REG_SIZE-1:0]        reg_in,
  input  logic                       reg_enable,
  output logic [REG_SIZE-1:0]        reg_out,
  input  logic [TICK_WIDTH-1:0]      tick_in,
  input  logic [TICK_MODE_WIDTH-1:0] tick_mode,
  output logic [TICK_WIDTH-1:0]      tick_out
);

  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = 1;
  localparam logic [TICK_WIDTH-1:0]  TICK_ONE  = 1;
  localparam logic [TICK_WIDTH-1:0]  TICK_MAX  = '1;
  localparam logic [TICK_WIDTH-1:0]  TICK_MIN  = '0;

  logic [TICK_WIDTH-1:0] tick_next;

  // Counter has no enable; it wraps naturally at its declared width.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_out <= '0;
    end else begin
      count_out <= count_out + COUNT_ONE;
    end
  end

  width_register #(
    .SIZE (REG_SIZE)
  ) u_plain_reg (
    .clk    (clk),
    .rst    (rst),
    .in     (reg_in),
    .enable (reg_enable),
    .out    (reg_out)
  );

  always_comb begin
    tick_next = tick_out;
    case (tick_mode)
      TICK_REGISTER_MODE_HOLD: tick_next = tick_out;
      TICK_REGISTER_MODE_SET:  tick_next = tick_in;
`ifdef TICK_SATURATE_EN
      TICK_REGISTER_MODE_INC: begin
        if (tick_out != TICK_MAX) tick_next = tick_out + TICK_ONE;
      end
      TICK_REGISTER_MODE_DEC: begin
        if (tick_out != TICK_MIN) tick_next = tick_out - TICK_ONE;
      end
`else
      TICK_REGISTER_MODE_INC:  tick_next = tick_out + TICK_ONE;
      TICK_REGISTER_MODE_DEC:  tick_next = tick_out - TICK_ONE;
`endif
      default:                 tick_next = tick_out;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_out <= '0;
    end else begin
      tick_out <= tick_next;
    end
  end

endmodule

// File: tb/tb_tick_counter_regs.sv
// Bench for tick_counter_regs: arithmetic reference model checked every cycle plus directed literals.
module tb_tick_counter_regs;
  import tick_counter_regs_pkg::*;

  localparam int CW = 6;
  localparam int RW = 4;
  localparam int TW = 8;
  localparam int CMOD = 1 << CW;
  localparam int TMOD = 1 << TW;

  logic                       clk;
  logic                       rst;
  logic [CW-1:0]              count_out;
  logic [RW-1:0]              reg_in;
  logic                       reg_enable;
  logic [RW-1:0]              reg_out;
  logic [TW-1:0]              tick_in;
  logic [TICK_MODE_WIDTH-1:0] tick_mode;
  logic [TW-1:0]              tick_out;

  int total = 0;
  int bad   = 0;

  tick_counter_regs #(
    .COUNT_WIDTH (CW),
    .REG_SIZE    (RW),
    .TICK_WIDTH  (TW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .count_out  (count_out),
    .reg_in     (reg_in),
    .reg_enable (reg_enable),
    .reg_out    (reg_out),
    .tick_in    (tick_in),
    .tick_mode  (tick_mode),
    .tick_out   (tick_out)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // reference model: plain integer arithmetic on the documented rules
  int m_count, m_reg, m_tick;
  bit known = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_count = 0;
      m_reg   = 0;
      m_tick  = 0;
      known   = 1;
    end else if (known) begin
      m_count = (m_count + 1) % CMOD;
      if (reg_enable) m_reg = int'(reg_in);
      if (tick_mode == TICK_REGISTER_MODE_SET) begin
        m_tick = int'(tick_in);
      end else if (tick_mode == TICK_REGISTER_MODE_INC) begin
`ifdef TICK_SATURATE_EN
        m_tick = (m_tick == TMOD - 1) ? m_tick : m_tick + 1;
`else
        m_tick = (m_tick + 1) % TMOD;
`endif
      end else if (tick_mode == TICK_REGISTER_MODE_DEC) begin
`ifdef TICK_SATURATE_EN
        m_tick = (m_tick == 0) ? 0 : m_tick - 1;
`else
        m_tick = (m_tick + TMOD - 1) % TMOD;
`endif
      end
    end
  end

  // compare process: every cycle once the model has seen a reset edge
  always @(negedge clk) begin
    if (known) begin
      total++;
      if (int'(count_out) !== m_count) begin
        bad++;
        $display("FAIL model_count t=%0t got=%0d want=%0d", $time, count_out, m_count);
      end
      total++;
      if (int'(reg_out) !== m_reg) begin
        bad++;
        $display("FAIL model_reg t=%0t got=%0d want=%0d", $time, reg_out, m_reg);
      end
      total++;
      if (int'(tick_out) !== m_tick) begin
        bad++;
        $display("FAIL model_tick t=%0t got=%0d want=%0d", $time, tick_out, m_tick);
      end
    end
  end

  // scoreboard
  logic [TW-1:0] exp_q[$];

  task automatic check(input string name, input logic [TW-1:0] got, input logic [TW-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, got, want);
    end
  endtask

  // driver tasks: inputs change only on the falling edge
  task automatic drive(input logic r, input logic [RW-1:0] ri, input logic re,
                       input logic [TW-1:0] ti, input logic [TICK_MODE_WIDTH-1:0] tm);
    rst        = r;
    reg_in     = ri;
    reg_enable = re;
    tick_in    = ti;
    tick_mode  = tm;
  endtask

  task automatic step(input logic r, input logic [RW-1:0] ri, input logic re,
                      input logic [TW-1:0] ti, input logic [TICK_MODE_WIDTH-1:0] tm);
    drive(r, ri, re, ti, tm);
    @(negedge clk);
  endtask

  initial begin
    logic [RW-1:0] prev;
    logic [TW-1:0] w;
    bit found;

    drive(1'b1, '0, 1'b0, '0, TICK_REGISTER_MODE_HOLD);
    repeat (2) @(negedge clk);
    check("reset_count", TW'(count_out), 8'h00);
    check("reset_reg", TW'(reg_out), 8'h00);
    check("reset_tick", tick_out, 8'h00);

    // 1. counter runs 1..63 then wraps to 0 on the 64th edge
    for (int k = 1; k <= 64; k++) exp_q.push_back(TW'(k % CMOD));
    rst = 1'b0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      w = exp_q.pop_front();
      check("count_seq", TW'(count_out), w);
    end

    // 2. plain register follows the prior cycle's count[3:0], then freezes
    for (int i = 0; i < 8; i++) begin
      prev = count_out[3:0];
      step(1'b0, prev, 1'b1, 8'h00, TICK_REGISTER_MODE_HOLD);
      check("reg_load", TW'(reg_out), TW'(prev));
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, count_out[3:0] ^ 4'hA, 1'b0, 8'h00, TICK_REGISTER_MODE_HOLD);
      check("reg_hold", TW'(reg_out), TW'(prev));
    end

    // 3. SET then alternating HOLD/SET keeps 0x05
    step(1'b0, '0, 1'b0, 8'h05, TICK_REGISTER_MODE_SET);
    check("tick_set", tick_out, 8'h05);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, 1'b0, 8'h33, TICK_REGISTER_MODE_HOLD);
      check("tick_hold", tick_out, 8'h05);
      step(1'b0, '0, 1'b0, 8'h05, TICK_REGISTER_MODE_SET);
      check("tick_reset5", tick_out, 8'h05);
    end

    // 4. INC x3, DEC, and both boundaries
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 8'h77, TICK_REGISTER_MODE_INC);
    check("tick_inc3", tick_out, 8'h08);
    step(1'b0, '0, 1'b0, 8'h77, TICK_REGISTER_MODE_DEC);
    check("tick_dec", tick_out, 8'h07);
    step(1'b0, '0, 1'b0, 8'h00, TICK_REGISTER_MODE_SET);
    step(1'b0, '0, 1'b0, 8'h11, TICK_REGISTER_MODE_DEC);
`ifdef TICK_SATURATE_EN
    check("tick_dec_zero", tick_out, 8'h00);
`else
    check("tick_dec_zero", tick_out, 8'hFF);
`endif
    step(1'b0, '0, 1'b0, 8'hFF, TICK_REGISTER_MODE_SET);
    step(1'b0, '0, 1'b0, 8'h11, TICK_REGISTER_MODE_INC);
`ifdef TICK_SATURATE_EN
    check("tick_inc_max", tick_out, 8'hFF);
`else
    check("tick_inc_max", tick_out, 8'h00);
`endif
    step(1'b0, 4'h9, 1'b1, 8'hC3, TICK_REGISTER_MODE_SET);
    check("tick_set_c3", tick_out, 8'hC3);

    // 5. reset beats reg_enable and SET; nothing changes before the edge
    drive(1'b1, 4'hF, 1'b1, 8'hAA, TICK_REGISTER_MODE_SET);
    #1;
    check("pre_edge_tick", tick_out, 8'hC3);
    check("pre_edge_reg", TW'(reg_out), 8'h09);
    @(negedge clk);
    check("rst_count", TW'(count_out), 8'h00);
    check("rst_reg", TW'(reg_out), 8'h00);
    check("rst_tick", tick_out, 8'h00);

    // 6. reset pulse at count 37, then 1,2,3
    step(1'b0, '0, 1'b0, '0, TICK_REGISTER_MODE_INC);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (count_out == 6'd37) found = 1;
      else step(1'b0, '0, 1'b0, '0, TICK_REGISTER_MODE_HOLD);
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL wait_count37 got=%0d want=37", count_out);
    end
    step(1'b1, '0, 1'b0, '0, TICK_REGISTER_MODE_HOLD);
    check("mid_rst_count", TW'(count_out), 8'h00);
    for (int k = 1; k <= 3; k++) begin
      step(1'b0, '0, 1'b0, '0, TICK_REGISTER_MODE_HOLD);
      w = TW'(k);
      check("post_rst_count", TW'(count_out), w);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
